// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller: state codes, opcode/funct
// constants and ALU control codes.
package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_aludec.sv
// R-type ALU decoder: funct -> ALU control code plus a legality flag.
module mc_aludec
  import mc_controller_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_legal_o
);

  always_comb begin
    alucontrol_o  = ALU_ADD;
    funct_legal_o = 1'b1;
    case (funct_i)
      F_ADD:   alucontrol_o = ALU_ADD;
      F_SUB:   alucontrol_o = ALU_SUB;
      F_AND:   alucontrol_o = ALU_AND;
      F_OR:    alucontrol_o = ALU_OR;
      F_SLT:   alucontrol_o = ALU_SLT;
      default: funct_legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with a stallable unified memory handshake and optional
// access timeout. Define MCCTRL_BNE_EN to decode bne as a branch.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state
);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            waiting, timeout;
  logic [2:0]      rtype_alu;
  logic            funct_legal;
  logic            bne_hit;

  mc_aludec u_aludec (
    .funct_i       (funct),
    .alucontrol_o  (rtype_alu),
    .funct_legal_o (funct_legal)
  );

`ifdef MCCTRL_BNE_EN
  assign bne_hit = (op == OP_BNE);
`else
  assign bne_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                   && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (cnt_q == TO_W'(MEM_TIMEOUT - 1));
  assign state   = state_q;

  always_comb begin
    state_d    = state_q;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    illegal    = 1'b0;
    mem_err    = timeout;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcen    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_legal) state_d = S_EXECUTE;
            else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEXEC;
          OP_J:    state_d = S_JUMP;
          default: begin
            if (bne_hit) state_d = S_BRANCH;
            else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = bne_hit ? ~zero : zero;
        state_d    = S_FETCH;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A timed-out access abandons the instruction (or restarts the fetch).
    if (timeout) state_d = S_FETCH;

    cnt_d = cnt_q;
    if ((state_d != state_q) || timeout) cnt_d = '0;
    else if (waiting)                    cnt_d = cnt_q + 1'b1;

    if (!reset) begin
      memread    = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      irwrite    = 1'b0;
      pcen       = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucontrol = 3'b000;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      illegal    = 1'b0;
      mem_err    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: instruction-level reference model pushes the
// expected per-cycle control vector, a negedge monitor pops and compares.
module tb_mc_controller;

  localparam int MEM_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       memread, memwrite, iord, irwrite, pcen, alusrca;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;
  logic       regdst, memtoreg, regwrite, illegal, mem_err;
  logic [3:0] state;

  mc_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .memread(memread), .memwrite(memwrite), .iord(iord),
    .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal),
    .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic mrd, mwr, iord, irw, pcen;
    logic [1:0] pcsrc;
    logic asa;
    logic [1:0] asb;
    logic [2:0] alu;
    logic rdst, m2r, rw, ill, merr;
  } ov_t;

  typedef struct {
    ov_t   v;
    string name;
  } exp_t;

  ov_t  act;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  assign act = {state, memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
                alusrcb, alucontrol, regdst, memtoreg, regwrite, illegal, mem_err};

  // Monitor: one expected vector per clock cycle, compared mid-cycle.
  exp_t cur;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (act !== cur.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h (state got %0d want %0d)",
                 cur.name, act, cur.v, act.st, cur.v.st);
      end
    end
  end

  // ---------------- reference model ----------------
  localparam logic [5:0] LEGAL_F [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  localparam logic [2:0] F_ALU   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  // 0 illegal, 1 lw, 2 sw, 3 R-type, 4 beq, 5 addi, 6 j, 7 bne
  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000000: begin
        for (int i = 0; i < 5; i++) if (f == LEGAL_F[i]) return 3;
        return 0;
      end
      6'b000100: return 4;
      6'b001000: return 5;
      6'b000010: return 6;
`ifdef MCCTRL_BNE_EN
      6'b000101: return 7;
`endif
      default:   return 0;
    endcase
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    for (int i = 0; i < 5; i++) if (f == LEGAL_F[i]) return F_ALU[i];
    return 3'b010;
  endfunction

  function automatic ov_t base(input int st);
    ov_t o;
    o     = '0;
    o.st  = 4'(st);
    o.alu = 3'b010;
    return o;
  endfunction

  // Push expectation for this cycle, then step to just after the next edge.
  task automatic cyc(input ov_t e, input string nm);
    exp_t x;
    x.v = e;
    x.name = nm;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Non-memory cycle: mem_ready and (optionally) zero are don't-cares.
  task automatic ncyc(input ov_t e, input string nm, input bit rand_zero);
    mem_ready = 1'($urandom_range(0, 1));
    if (rand_zero) zero = 1'($urandom_range(0, 1));
    cyc(e, nm);
  endtask

  task automatic mem_phase(input int st, input int waits, input string nm, output bit to);
    ov_t e;
    to = 1'b0;
    for (int w = 0; w <= waits; w++) begin
      bit rdy;
      bit tmo;
      rdy = (w == waits);
      tmo = !rdy && (w == MEM_TIMEOUT - 1);
      mem_ready = rdy;
      zero = 1'($urandom_range(0, 1));
      e = base(st);
      case (st)
        0: begin e.mrd = 1'b1; e.asb = 2'b01; e.irw = rdy; e.pcen = rdy; end
        3: begin e.iord = 1'b1; e.mrd = 1'b1; end
        default: begin e.iord = 1'b1; e.mwr = 1'b1; end
      endcase
      e.merr = tmo;
      cyc(e, tmo ? {nm, "_timeout"} : nm);
      if (tmo) begin
        to = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int wf, input int wm);
    ov_t e;
    bit  to;
    int  cls;
    op = o;
    funct = f;
    mem_phase(0, wf, "fetch", to);
    if (to) return;
    cls = classify(o, f);
    e = base(1);
    e.asb = 2'b11;
    e.ill = (cls == 0);
    ncyc(e, "decode", 1'b1);
    case (cls)
      1, 2: begin
        e = base(2); e.asa = 1'b1; e.asb = 2'b10;
        ncyc(e, "memadr", 1'b1);
        if (cls == 1) begin
          mem_phase(3, wm, "memrd", to);
          if (!to) begin
            e = base(4); e.m2r = 1'b1; e.rw = 1'b1;
            ncyc(e, "memwb", 1'b1);
          end
        end else begin
          mem_phase(5, wm, "memwr", to);
        end
      end
      3: begin
        e = base(6); e.asa = 1'b1; e.alu = ref_alu(f);
        ncyc(e, "execute", 1'b1);
        e = base(7); e.rdst = 1'b1; e.rw = 1'b1;
        ncyc(e, "aluwb", 1'b1);
      end
      4, 7: begin
        zero = z;
        e = base(8); e.asa = 1'b1; e.alu = 3'b110; e.pcsrc = 2'b01;
        e.pcen = (cls == 7) ? ~z : z;
        ncyc(e, "branch", 1'b0);
      end
      5: begin
        e = base(9); e.asa = 1'b1; e.asb = 2'b10;
        ncyc(e, "addiexec", 1'b1);
        e = base(10); e.rw = 1'b1;
        ncyc(e, "addiwb", 1'b1);
      end
      6: begin
        e = base(11); e.pcsrc = 2'b10; e.pcen = 1'b1;
        ncyc(e, "jump", 1'b1);
      end
      default: ;
    endcase
  endtask

  function automatic int rand_wait();
    return ($urandom_range(0, 19) == 0) ? MEM_TIMEOUT + int'($urandom_range(0, 2))
                                        : int'($urandom_range(0, 3));
  endfunction

  localparam logic [5:0] OPS [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                      6'b001000, 6'b000010, 6'b000101};

  initial begin
    bit to;
    ov_t e;
    logic [5:0] o, f;
    reset = 1'b0;
    mem_ready = 1'b1;
    op = 6'b100011;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc('0, "reset_hold");
    reset = 1'b1;

    // Directed cases
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);        // lw, no waits
    run_instr(6'b000000, 6'b100010, 1'b0, 3, 0);        // sub, fetch stalls 3
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);        // beq taken
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);        // beq not taken
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);        // j
    run_instr(6'b111111, 6'b100000, 1'b0, 0, 0);        // bad opcode
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);        // bad funct
    run_instr(6'b000101, 6'b000000, 1'b1, 0, 0);        // bne
    run_instr(6'b101011, 6'b000000, 1'b0, 0, MEM_TIMEOUT); // sw timeout
    run_instr(6'b100011, 6'b000000, 1'b0, 0, MEM_TIMEOUT); // lw timeout
    run_instr(6'b001000, 6'b000000, 1'b0, MEM_TIMEOUT, 0); // fetch timeout
    run_instr(6'b001000, 6'b000000, 1'b0, 1, 0);        // addi

    // Reset asserted in the middle of a load's memory wait
    op = 6'b100011;
    mem_phase(0, 0, "fetch", to);
    e = base(1); e.asb = 2'b11;
    ncyc(e, "decode", 1'b1);
    e = base(2); e.asa = 1'b1; e.asb = 2'b10;
    ncyc(e, "memadr", 1'b1);
    mem_ready = 1'b0;
    e = base(3); e.iord = 1'b1; e.mrd = 1'b1;
    cyc(e, "memrd_wait");
    reset = 1'b0;
    mem_ready = 1'b1;
    cyc('0, "reset_mid");
    cyc('0, "reset_mid");
    reset = 1'b1;
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        8:       o = 6'($urandom);
        9:       o = 6'b000000;
        default: o = OPS[$urandom_range(0, 6)];
      endcase
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : LEGAL_F[$urandom_range(0, 4)];
      run_instr(o, f, 1'($urandom_range(0, 1)), rand_wait(), rand_wait());
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
